// File: rtl/tx_scheduler.sv
// Round-robin transmit scheduler feeding one payload burst at a time into network_stack.
// Define TX_SCHED_PRIORITY_EN to give requester 0 strict priority over the others.
module tx_scheduler #(
   parameter int unsigned NREQ          = 4,
   parameter int unsigned DATA_SIZE     = 16,
   parameter int unsigned MAX_WORDS     = 32,
   parameter int unsigned START_TIMEOUT = 1024,
   parameter int unsigned HOLDOFF       = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*8-1:0]         req_len,
   input  logic [NREQ*32-1:0]        req_dst_ip,
   input  logic [NREQ*16-1:0]        req_src_port,
   input  logic [NREQ*16-1:0]        req_dst_port,
   input  logic [NREQ*DATA_SIZE-1:0] src_data,
   output logic [NREQ-1:0]           src_rd,
   output logic [NREQ-1:0]           grant,
   output logic [NREQ-1:0]           done,
   output logic [NREQ-1:0]           err,
   output logic                      stack_axiiv,
   output logic [DATA_SIZE-1:0]      stack_axiid,
   output logic [31:0]               stack_dst_ip,
   output logic [15:0]               stack_src_port,
   output logic [15:0]               stack_dst_port,
   input  logic                      eth_txen,
   output logic                      busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF - 1);

   typedef enum logic [2:0] {
      StIdle, StGrant, StStream, StWaitStart, StWaitDone, StHoldoff
   } state_t;

   state_t               state_q;
   logic [IW-1:0]        sel_q, last_q, next_last;
   logic [7:0]           len_q;
   logic [CW-1:0]        cnt_q;

   logic [IW-1:0]        pick, idx;
   logic                 pick_vld;
   logic [NREQ-1:0]      rr_req;
   logic [7:0]           cur_len;
   logic [DATA_SIZE-1:0] cur_data;
   logic [31:0]          cur_ip;
   logic [15:0]          cur_sport, cur_dport;

   assign busy = (state_q != StIdle);

   // Round-robin search from last_q+1; the lowest offset with a request wins.
   always_comb begin
      rr_req   = req;
`ifdef TX_SCHED_PRIORITY_EN
      rr_req[0] = 1'b0;
`endif
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int off = int'(NREQ); off >= 1; off--) begin
         idx = IW'((int'(last_q) + off) % int'(NREQ));
         if (rr_req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
`ifdef TX_SCHED_PRIORITY_EN
      if (req[0]) begin
         pick     = '0;
         pick_vld = 1'b1;
      end
`endif
   end

   // Requester 0 grants leave the round-robin pointer of the others untouched.
`ifdef TX_SCHED_PRIORITY_EN
   assign next_last = (sel_q != '0) ? sel_q : last_q;
`else
   assign next_last = sel_q;
`endif

   always_comb begin
      cur_len   = '0;
      cur_data  = '0;
      cur_ip    = '0;
      cur_sport = '0;
      cur_dport = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (sel_q == IW'(i)) begin
            cur_len   = req_len[i*8 +: 8];
            cur_data  = src_data[i*DATA_SIZE +: DATA_SIZE];
            cur_ip    = req_dst_ip[i*32 +: 32];
            cur_sport = req_src_port[i*16 +: 16];
            cur_dport = req_dst_port[i*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         sel_q          <= '0;
         last_q         <= IW'(NREQ - 1);
         len_q          <= '0;
         cnt_q          <= '0;
         src_rd         <= '0;
         grant          <= '0;
         done           <= '0;
         err            <= '0;
         stack_axiiv    <= 1'b0;
         stack_axiid    <= '0;
         stack_dst_ip   <= '0;
         stack_src_port <= '0;
         stack_dst_port <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         unique case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  sel_q   <= pick;
                  grant   <= NREQ'(1) << pick;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               if (cur_len == 8'd0 || cur_len > 8'(MAX_WORDS)) begin
                  err     <= grant;
                  grant   <= '0;
                  last_q  <= next_last;
                  state_q <= StIdle;
               end else begin
                  len_q          <= cur_len;
                  stack_dst_ip   <= cur_ip;
                  stack_src_port <= cur_sport;
                  stack_dst_port <= cur_dport;
                  src_rd         <= grant;
                  cnt_q          <= '0;
                  state_q        <= StStream;
               end
            end
            StStream: begin
               stack_axiid <= cur_data;
               stack_axiiv <= 1'b1;
               if (cnt_q == {{(CW-8){1'b0}}, len_q - 8'd1}) begin
                  src_rd  <= '0;
                  cnt_q   <= '0;
                  state_q <= StWaitStart;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitStart: begin
               stack_axiiv <= 1'b0;
               if (eth_txen) begin
                  cnt_q   <= '0;
                  state_q <= StWaitDone;
               end else if (cnt_q == TO_LAST) begin
                  err     <= grant;
                  cnt_q   <= '0;
                  state_q <= StHoldoff;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitDone: begin
               if (!eth_txen) begin
                  done    <= grant;
                  cnt_q   <= '0;
                  state_q <= StHoldoff;
               end
            end
            StHoldoff: begin
               if (cnt_q == HO_LAST) begin
                  grant   <= '0;
                  last_q  <= next_last;
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: vector table of transactions plus reset and priority sequences.
module tb_tx_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 16;

   logic               clk, rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*8-1:0]  req_len;
   logic [NREQ*32-1:0] req_dst_ip;
   logic [NREQ*16-1:0] req_src_port, req_dst_port;
   logic [NREQ*DW-1:0] src_data;
   logic [NREQ-1:0]    src_rd, grant, done, err;
   logic               stack_axiiv, eth_txen, busy;
   logic [DW-1:0]      stack_axiid;
   logic [31:0]        stack_dst_ip;
   logic [15:0]        stack_src_port, stack_dst_port;

   int checks = 0;
   int errors = 0;
   int hdr_idx = -1;

   logic       ptr_clr;
   logic [7:0] ptr [NREQ];

   tx_scheduler #(
      .NREQ(NREQ), .DATA_SIZE(DW), .MAX_WORDS(32), .START_TIMEOUT(1024), .HOLDOFF(64)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_dst_ip(req_dst_ip),
      .req_src_port(req_src_port), .req_dst_port(req_dst_port), .src_data(src_data),
      .src_rd(src_rd), .grant(grant), .done(done), .err(err), .stack_axiiv(stack_axiiv),
      .stack_axiid(stack_axiid), .stack_dst_ip(stack_dst_ip), .stack_src_port(stack_src_port),
      .stack_dst_port(stack_dst_port), .eth_txen(eth_txen), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] word(input int i, input int k);
      return 16'hA000 | 16'(i << 8) | 16'(k);
   endfunction

   function automatic logic [63:0] hdr_exp(input int i);
      if (i < 0) return 64'd0;
      return {32'h0A00_0001 + 32'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i)};
   endfunction

   // Fall-through sources: word k of requester i is visible until popped.
   always @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (ptr_clr) ptr[i] <= 8'd0;
         else if (src_rd[i]) ptr[i] <= ptr[i] + 8'd1;
      end
   end

   always_comb begin
      src_data = '0;
      for (int i = 0; i < NREQ; i++) src_data[i*DW +: DW] = word(i, int'(ptr[i]));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_txn(input logic [3:0] r, input logic [7:0] l, input int idx, input bit bad,
                         input int frame, input logic [3:0] r_late);
      logic [3:0] oh;
      int mis;
      oh = 4'b0001 << idx;
      req = r;
      for (int i = 0; i < NREQ; i++) req_len[i*8 +: 8] = l;
      ptr_clr = 1'b1;
      @(negedge clk);
      ptr_clr = 1'b0;
      check("grant", {src_rd, grant, busy, stack_axiiv}, {4'b0, oh, 1'b1, 1'b0});
      @(negedge clk);
      if (bad) begin
         check("reject", {err, grant, src_rd, busy, stack_axiiv}, {oh, 4'b0, 4'b0, 1'b0, 1'b0});
         check("hdr_hold", {stack_dst_ip, stack_src_port, stack_dst_port}, hdr_exp(hdr_idx));
         req = '0;
         @(negedge clk);
         check("err_pulse", {err, stack_axiiv, busy}, 6'b0);
         return;
      end
      hdr_idx = idx;
      check("header", {stack_dst_ip, stack_src_port, stack_dst_port}, hdr_exp(idx));
      mis = 0;
      for (int c = 0; c <= int'(l); c++) begin
         if (c > 0) @(negedge clk);
         if (src_rd !== ((c < int'(l)) ? oh : 4'b0)) mis++;
         if (stack_axiiv !== (c > 0)) mis++;
         if (c > 0 && stack_axiid !== word(idx, c - 1)) mis++;
         if (err !== 4'b0 || done !== 4'b0) mis++;
      end
      check("stream", 64'(mis), 64'd0);
      mis = 0;
      if (frame > 0) begin
         @(negedge clk);
         check("axiiv_fall", {63'd0, stack_axiiv}, 64'd0);
         eth_txen = 1'b1;
         for (int f = 0; f < frame; f++) begin
            @(negedge clk);
            if (done !== 4'b0 || err !== 4'b0 || grant !== oh) mis++;
         end
         eth_txen = 1'b0;
         @(negedge clk);
         check("done", {done, err}, {oh, 4'b0});
      end else begin
         for (int j = 1; j < 1024; j++) begin
            @(negedge clk);
            if (err !== 4'b0 || done !== 4'b0 || stack_axiiv !== 1'b0) mis++;
         end
         @(negedge clk);
         check("timeout_err", {err, done}, {oh, 4'b0});
      end
      check("wait", 64'(mis), 64'd0);
      req = r_late;
      mis = 0;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         if (grant !== oh || busy !== 1'b1 || done !== 4'b0 || err !== 4'b0) mis++;
      end
      check("holdoff", 64'(mis), 64'd0);
      @(negedge clk);
      check("release", {grant, busy}, 5'b0);
   endtask

   typedef struct {
      logic [3:0] r;
      logic [7:0] l;
      int         idx;
      bit         bad;
      int         frame;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int mis;
      vecs[0]  = '{4'b1111, 8'd3,  0, 1'b0, 40};
      vecs[1]  = '{4'b1111, 8'd3,  1, 1'b0, 40};
      vecs[2]  = '{4'b1111, 8'd3,  2, 1'b0, 40};
      vecs[3]  = '{4'b1111, 8'd3,  3, 1'b0, 40};
      vecs[4]  = '{4'b1111, 8'd3,  0, 1'b0, 40};
      vecs[5]  = '{4'b0010, 8'd3,  1, 1'b0, 40};
      vecs[6]  = '{4'b0100, 8'd0,  2, 1'b1, 0};
      vecs[7]  = '{4'b1000, 8'd33, 3, 1'b1, 0};
      vecs[8]  = '{4'b0001, 8'd32, 0, 1'b0, 40};
      vecs[9]  = '{4'b0100, 8'd1,  2, 1'b0, 40};
      vecs[10] = '{4'b0010, 8'd2,  1, 1'b0, 0};
      vecs[11] = '{4'b0110, 8'd3,  2, 1'b0, 40};

      rst = 1'b1;
      req = '0;
      req_len = '0;
      eth_txen = 1'b0;
      ptr_clr = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         req_dst_ip[i*32 +: 32]   = 32'h0A00_0001 + 32'(i);
         req_src_port[i*16 +: 16] = 16'h1000 + 16'(i);
         req_dst_port[i*16 +: 16] = 16'h2000 + 16'(i);
      end
      repeat (3) @(negedge clk);
      check("reset_ctl", {grant, src_rd, done, err, busy, stack_axiiv}, 64'd0);
      check("reset_hdr", {stack_axiid, stack_dst_ip, stack_src_port}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

`ifdef TX_SCHED_PRIORITY_EN
      do_txn(4'b1110, 8'd3, 1, 1'b0, 40, 4'b1111);
      do_txn(4'b1111, 8'd3, 0, 1'b0, 40, 4'b1111);
      do_txn(4'b1110, 8'd3, 2, 1'b0, 40, 4'b1110);
`else
      for (int v = 0; v < 12; v++)
         do_txn(vecs[v].r, vecs[v].l, vecs[v].idx, vecs[v].bad, vecs[v].frame, vecs[v].r);
`endif

      // Reset while the second word of a five-word burst is on the stack interface.
      req = 4'b0100;
      for (int i = 0; i < NREQ; i++) req_len[i*8 +: 8] = 8'd5;
      ptr_clr = 1'b1;
      @(negedge clk);
      ptr_clr = 1'b0;
      check("mid_grant", {28'd0, grant}, 64'h4);
      repeat (3) @(negedge clk);
      check("mid_word", {stack_axiiv, stack_axiid}, {1'b1, word(2, 1)});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      check("mid_rst_ctl", {grant, src_rd, done, err, busy, stack_axiiv}, 64'd0);
      check("mid_rst_hdr", {stack_axiid, stack_dst_ip, stack_src_port}, 64'd0);
      hdr_idx = -1;
      mis = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 4'b0 || err !== 4'b0 || stack_axiiv !== 1'b0 || busy !== 1'b0) mis++;
      end
      check("post_rst_quiet", 64'(mis), 64'd0);
      do_txn(4'b0101, 8'd3, 0, 1'b0, 40, 4'b0101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
